// File: rtl/param_add_accum_if.sv
// Operand/result handshake bundle for param_add_accum.
// master = producer/consumer side, slave = the arithmetic unit.
interface param_add_accum_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           op;
  logic                 sat;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 carry;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_ovf;
  logic [CNT_WIDTH-1:0] op_count;

  modport master (
    output in_valid, a, b, op, sat, out_ready,
    input  in_ready, out_valid, result, carry, ovf, acc, acc_ovf, op_count
  );

  modport slave (
    input  in_valid, a, b, op, sat, out_ready,
    output in_ready, out_valid, result, carry, ovf, acc, acc_ovf, op_count
  );
endinterface

// File: rtl/param_add_accum.sv
// Registered add/sub/accumulate unit with carry, signed overflow, saturation,
// a wide running accumulator and an accepted-operation counter.
module param_add_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  param_add_accum_if.slave bus
);
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  localparam int MSB = WIDTH - 1;

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 carry_reg, carry_next;
  logic                 ovf_reg, ovf_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic                 acc_ovf_reg, acc_ovf_next;
  logic [CNT_WIDTH-1:0] count_reg;

  logic                 in_ready;
  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [ACC_WIDTH:0]   acc_sum;
  op_t                  op_sel;

  assign op_sel   = op_t'(bus.op);
  assign in_ready = !out_valid_reg || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Top bit of the one-bit-wider difference is the unsigned borrow (a < b).
  assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff    = {1'b0, bus.a} - {1'b0, bus.b};
  assign acc_sum = {1'b0, acc_reg} + {{(ACC_WIDTH - WIDTH + 1){1'b0}}, bus.a};

  always_comb begin
    result_next  = sum[MSB:0];
    carry_next   = 1'b0;
    ovf_next     = 1'b0;
    acc_next     = acc_reg;
    acc_ovf_next = acc_ovf_reg;
    case (op_sel)
      OP_ADD: begin
        carry_next  = sum[WIDTH];
        result_next = (bus.sat && sum[WIDTH]) ? '1 : sum[MSB:0];
        ovf_next    = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        carry_next  = diff[WIDTH];
        result_next = (bus.sat && diff[WIDTH]) ? '0 : diff[MSB:0];
        ovf_next    = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_ACC: begin
        carry_next   = acc_sum[ACC_WIDTH];
        acc_next     = (bus.sat && acc_sum[ACC_WIDTH]) ? '1 : acc_sum[ACC_WIDTH-1:0];
        acc_ovf_next = acc_ovf_reg || acc_sum[ACC_WIDTH];
        result_next  = acc_next[MSB:0];
      end
      OP_CLR: begin
        result_next  = '0;
        acc_next     = '0;
        acc_ovf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      acc_reg       <= '0;
      acc_ovf_reg   <= 1'b0;
      count_reg     <= '0;
    end else begin
      // Accept wins over consume, so a simultaneous consume+accept keeps valid high.
      out_valid_reg <= accept || (out_valid_reg && !bus.out_ready);
      if (accept) begin
        result_reg  <= result_next;
        carry_reg   <= carry_next;
        ovf_reg     <= ovf_next;
        acc_reg     <= acc_next;
        acc_ovf_reg <= acc_ovf_next;
        count_reg   <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.carry     = carry_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.acc       = acc_reg;
  assign bus.acc_ovf   = acc_ovf_reg;
  assign bus.op_count  = count_reg;
endmodule
